// File: rtl/spi_flash_reader_if.sv
// Bundle of the start/stream handshake and the Wishbone link to spi_wb8.
// The master modport is the reader's view; the slave modport is the
// environment's view (start source, byte consumer and spi_wb8).
interface spi_flash_reader_if;
    logic        start;
    logic [23:0] addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [1:0]  wb_adr;
    logic [7:0]  wb_wdata;
    logic        wb_we;
    logic        wb_stb;
    logic [7:0]  wb_rdata;
    logic        wb_ack;

    modport master (
        input  start, addr, len, ready, wb_rdata, wb_ack,
        output busy, done, error, data, valid, wb_adr, wb_wdata, wb_we, wb_stb
    );

    modport slave (
        output start, addr, len, ready, wb_rdata, wb_ack,
        input  busy, done, error, data, valid, wb_adr, wb_wdata, wb_we, wb_stb
    );
endinterface

// File: rtl/spi_flash_reader.sv
// Wishbone master driving spi_wb8 through a serial-flash READ: CS low,
// opcode, 24-bit address, then one fill byte per data byte with each
// received byte handed out on a valid/ready port, CS high, done pulse.
//
// state  | meaning
// IDLE   | waiting for start
// CS_ON  | write CS control = 0 (select flash)
// CMD    | write read opcode to data register
// ADDR   | write address byte idx (2 = MSB)
// XFER   | write fill byte to clock in one data byte
// POLL   | read status until transfer not busy, or time out
// RDDAT  | read received byte into the output register
// OUT    | hold byte until consumer accepts it
// CS_OFF | write CS control = 1 (release flash)
// DONE   | one-cycle done pulse
module spi_flash_reader #(
    parameter logic [7:0] CMD_READ     = 8'h03,
    parameter logic [7:0] FILL_BYTE    = 8'hFF,
    parameter int         POLL_TIMEOUT = 4096
) (
    input logic               clk,
    input logic               rst,
    spi_flash_reader_if.master bus
);

    localparam int PW = $clog2(POLL_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, CS_ON, CMD, ADDR, XFER, POLL, RDDAT, OUT, CS_OFF, DONE
    } state_t;

    state_t        state_q, state_nxt;
    state_t        ret_q, ret_nxt;
    logic [1:0]    idx_q, idx_nxt;
    logic [23:0]   addr_q, addr_nxt;
    logic [15:0]   rem_q, rem_nxt;
    logic [PW-1:0] poll_q, poll_nxt;
    logic          stb_q, stb_nxt;
    logic          we_q, we_nxt;
    logic [1:0]    adr_q, adr_nxt;
    logic [7:0]    wdat_q, wdat_nxt;
    logic [7:0]    data_q, data_nxt;
    logic          valid_q, valid_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;
    logic          error_q, error_nxt;

    logic          bus_state;
    logic          bus_done;
    logic [1:0]    req_adr;
    logic          req_we;
    logic [7:0]    req_wdat;
    logic [7:0]    addr_byte;

    // Register every piece of state; all bus and stream outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            idx_q   <= 2'd0;
            addr_q  <= 24'd0;
            rem_q   <= 16'd0;
            poll_q  <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 2'd0;
            wdat_q  <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ret_q   <= ret_nxt;
            idx_q   <= idx_nxt;
            addr_q  <= addr_nxt;
            rem_q   <= rem_nxt;
            poll_q  <= poll_nxt;
            stb_q   <= stb_nxt;
            we_q    <= we_nxt;
            adr_q   <= adr_nxt;
            wdat_q  <= wdat_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            error_q <= error_nxt;
        end
    end

    // Next-state logic: pick the bus request for the current state, run the
    // generic strobe/ack handshake, then advance the sequence on ack.
    always_comb begin
        state_nxt = state_q;
        ret_nxt   = ret_q;
        idx_nxt   = idx_q;
        addr_nxt  = addr_q;
        rem_nxt   = rem_q;
        poll_nxt  = poll_q;
        stb_nxt   = stb_q;
        we_nxt    = we_q;
        adr_nxt   = adr_q;
        wdat_nxt  = wdat_q;
        data_nxt  = data_q;
        valid_nxt = valid_q;
        busy_nxt  = busy_q;
        done_nxt  = done_q;
        error_nxt = error_q;
        bus_state = 1'b0;
        req_adr   = 2'd0;
        req_we    = 1'b0;
        req_wdat  = 8'h00;

        case (idx_q)
            2'd2:    addr_byte = addr_q[23:16];
            2'd1:    addr_byte = addr_q[15:8];
            default: addr_byte = addr_q[7:0];
        endcase

        case (state_q)
            CS_ON:  begin bus_state = 1'b1; req_adr = 2'd2; req_we = 1'b1; req_wdat = 8'h00;     end
            CMD:    begin bus_state = 1'b1; req_adr = 2'd0; req_we = 1'b1; req_wdat = CMD_READ;  end
            ADDR:   begin bus_state = 1'b1; req_adr = 2'd0; req_we = 1'b1; req_wdat = addr_byte; end
            XFER:   begin bus_state = 1'b1; req_adr = 2'd0; req_we = 1'b1; req_wdat = FILL_BYTE; end
            POLL:   begin bus_state = 1'b1; req_adr = 2'd1; req_we = 1'b0;                       end
            RDDAT:  begin bus_state = 1'b1; req_adr = 2'd0; req_we = 1'b0;                       end
            CS_OFF: begin bus_state = 1'b1; req_adr = 2'd2; req_we = 1'b1; req_wdat = 8'h01;     end
            default: ;
        endcase

        // A new cycle only starts with stb low, which guarantees the idle
        // cycle after each ack before the next strobe.
        bus_done = bus_state && stb_q && bus.wb_ack;
        if (bus_state) begin
            if (!stb_q) begin
                stb_nxt  = 1'b1;
                adr_nxt  = req_adr;
                we_nxt   = req_we;
                wdat_nxt = req_wdat;
            end else if (bus.wb_ack) begin
                stb_nxt = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_nxt  = bus.addr;
                    rem_nxt   = bus.len;
                    error_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = CS_ON;
                end
            end
            CS_ON: if (bus_done) state_nxt = CMD;
            CMD: begin
                if (bus_done) begin
                    state_nxt = POLL;
                    ret_nxt   = ADDR;
                    idx_nxt   = 2'd2;
                    poll_nxt  = '0;
                end
            end
            ADDR: begin
                if (bus_done) begin
                    state_nxt = POLL;
                    poll_nxt  = '0;
                    if (idx_q != 2'd0) begin
                        ret_nxt = ADDR;
                        idx_nxt = idx_q - 2'd1;
                    end else begin
                        ret_nxt = (rem_q == 16'd0) ? CS_OFF : XFER;
                    end
                end
            end
            XFER: begin
                if (bus_done) begin
                    state_nxt = POLL;
                    ret_nxt   = RDDAT;
                    poll_nxt  = '0;
                end
            end
            POLL: begin
                if (bus_done) begin
                    if (bus.wb_rdata[0]) begin
                        if (poll_q == PW'(POLL_TIMEOUT - 1)) begin
                            error_nxt = 1'b1;
                            poll_nxt  = '0;
                            state_nxt = CS_OFF;
                        end else begin
                            poll_nxt = poll_q + 1'b1;
                        end
                    end else begin
                        poll_nxt  = '0;
                        state_nxt = ret_q;
                    end
                end
            end
            RDDAT: begin
                if (bus_done) begin
                    data_nxt  = bus.wb_rdata;
                    valid_nxt = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (bus.ready) begin
                    valid_nxt = 1'b0;
                    rem_nxt   = rem_q - 16'd1;
                    state_nxt = (rem_q != 16'd1) ? XFER : CS_OFF;
                end
            end
            CS_OFF: begin
                if (bus_done) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_nxt  = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.data     = data_q;
    assign bus.valid    = valid_q;
    assign bus.wb_adr   = adr_q;
    assign bus.wb_wdata = wdat_q;
    assign bus.wb_we    = we_q;
    assign bus.wb_stb   = stb_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural spi_wb8 + flash stand-in on the
// Wishbone side, queue scoreboards for MOSI bytes and streamed data.
module tb_spi_flash_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_flash_reader_if bus ();

    spi_flash_reader #(.CMD_READ(8'h03), .FILL_BYTE(8'hFF), .POLL_TIMEOUT(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_mosi[$];
    logic [7:0] exp_data[$];

    // slave / flash state
    logic        sl_ack = 1'b0;
    logic [7:0]  sl_rdata = 8'h00;
    logic        cs_level = 1'b1;
    int          busy_cnt = 0;
    bit          stuck_busy = 1'b0;
    int          lat = -1;
    logic [7:0]  miso_last = 8'h00;
    int          fl_cnt = 0;
    logic [23:0] fl_addr = 24'd0;
    int          mosi_cnt = 0;
    int          status_reads = 0;

    // monitor / driver state
    int          done_cnt = 0;
    int          out_idx = 0;
    bit          stall_req = 1'b0;
    bit          stall_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash contents as a pure function of address.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        logic [7:0] lo, mid, hi;
        lo  = a[7:0];
        mid = a[15:8];
        hi  = a[23:16];
        return {lo[4:0], lo[7:5]} ^ mid ^ (hi + 8'h3C);
    endfunction

    // Behavioural spi_wb8 with attached flash: random ack latency, random busy time.
    always @(negedge clk) begin
        logic [7:0]  wd;
        logic [7:0]  e;
        logic [23:0] off;
        if (busy_cnt > 0) busy_cnt--;
        if (rst) begin
            sl_ack   = 1'b0;
            lat      = -1;
            cs_level = 1'b1;
            busy_cnt = 0;
            fl_cnt   = 0;
            fl_addr  = 24'd0;
        end else if (sl_ack) begin
            sl_ack = 1'b0;
        end else if (bus.wb_stb) begin
            if (lat < 0) lat = int'($urandom_range(0, 2));
            if (lat == 0) begin
                lat = -1;
                sl_ack = 1'b1;
                wd = bus.wb_wdata;
                if (bus.wb_we) begin
                    if (bus.wb_adr == 2'd0) begin
                        check("cs_low_on_tx", 32'(cs_level), 32'd0);
                        check("mosi_expected", 32'(exp_mosi.size() > 0), 32'd1);
                        if (exp_mosi.size() > 0) begin
                            e = exp_mosi.pop_front();
                            check("mosi_byte", 32'(wd), 32'(e));
                        end
                        if (fl_cnt >= 4) begin
                            off = 24'(fl_cnt - 4);
                            miso_last = mem_byte(fl_addr + off);
                        end else begin
                            miso_last = 8'h00;
                        end
                        if (fl_cnt >= 1 && fl_cnt <= 3) fl_addr = {fl_addr[15:0], wd};
                        fl_cnt++;
                        busy_cnt = int'($urandom_range(0, 5));
                        mosi_cnt++;
                        status_reads = 0;
                    end else if (bus.wb_adr == 2'd2) begin
                        if (cs_level && !wd[0]) begin
                            fl_cnt  = 0;
                            fl_addr = 24'd0;
                        end
                        cs_level = wd[0];
                    end
                    sl_rdata = 8'h00;
                end else begin
                    if (bus.wb_adr == 2'd1) begin
                        sl_rdata = {7'd0, (stuck_busy || busy_cnt > 0)};
                        status_reads++;
                    end else if (bus.wb_adr == 2'd0) begin
                        sl_rdata = miso_last;
                    end else begin
                        sl_rdata = 8'h00;
                    end
                end
            end else begin
                lat--;
            end
        end
        bus.wb_ack   = sl_ack;
        bus.wb_rdata = sl_rdata;
    end

    // Monitor: stream scoreboard, done/busy rules and Wishbone cycle rules.
    initial begin
        logic        p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_valid = 1'b0, p_hs = 1'b0;
        logic        p_done = 1'b0, p_rst = 1'b1;
        logic [1:0]  p_adr = 2'd0;
        logic [7:0]  p_wdat = 8'd0, p_data = 8'd0, e;
        logic        hs;
        forever begin
            @(negedge clk);
            #2;
            hs = bus.valid && bus.ready;
            if (!rst && !p_rst) begin
                if (p_stb && !p_ack) begin
                    check("stb_held", 32'(bus.wb_stb), 32'd1);
                    check("bus_stable", 32'({bus.wb_adr, bus.wb_we, bus.wb_wdata}),
                          32'({p_adr, p_we, p_wdat}));
                end
                if (p_stb && p_ack) check("stb_drop_after_ack", 32'(bus.wb_stb), 32'd0);
                if (p_valid && !p_hs) begin
                    check("valid_held", 32'(bus.valid), 32'd1);
                    check("data_stable", 32'(bus.data), 32'(p_data));
                end
                if (hs) begin
                    check("data_expected", 32'(exp_data.size() > 0), 32'd1);
                    if (exp_data.size() > 0) begin
                        e = exp_data.pop_front();
                        check("data_byte", 32'(bus.data), 32'(e));
                    end
                    out_idx++;
                end
                if (bus.done) begin
                    check("busy_with_done", 32'(bus.busy), 32'd1);
                    check("cs_released_at_done", 32'(cs_level), 32'd1);
                    done_cnt++;
                end
                if (p_done) check("done_then_idle", 32'({bus.done, bus.busy}), 32'd0);
            end
            p_stb = bus.wb_stb; p_ack = bus.wb_ack; p_adr = bus.wb_adr; p_we = bus.wb_we;
            p_wdat = bus.wb_wdata; p_valid = bus.valid; p_hs = hs; p_data = bus.data;
            p_done = bus.done; p_rst = rst;
        end
    end

    // Consumer: random backpressure, plus one 50-cycle stall on byte index 1.
    initial begin
        int         m;
        logic [7:0] d;
        bus.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req && !stall_done && bus.valid && out_idx == 1) begin
                bus.ready = 1'b0;
                m = mosi_cnt;
                d = bus.data;
                repeat (50) @(posedge clk);
                #1;
                check("stall_valid", 32'(bus.valid), 32'd1);
                check("stall_data", 32'(bus.data), 32'(d));
                check("stall_no_spi", 32'(mosi_cnt), 32'(m));
                stall_done = 1'b1;
                bus.ready  = 1'b1;
            end else begin
                bus.ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic push_op(input logic [23:0] a, input logic [15:0] l);
        exp_mosi.push_back(8'h03);
        exp_mosi.push_back(a[23:16]);
        exp_mosi.push_back(a[15:8]);
        exp_mosi.push_back(a[7:0]);
        for (int i = 0; i < int'(l); i++) begin
            exp_mosi.push_back(8'hFF);
            exp_data.push_back(mem_byte(a + 24'(i)));
        end
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] l);
        mosi_cnt = 0;
        out_idx  = 0;
        @(posedge clk);
        #1;
        bus.addr  = a;
        bus.len   = l;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.addr  = 24'($urandom);
        bus.len   = 16'($urandom);
    endtask

    task automatic run_op(input logic [23:0] a, input logic [15:0] l,
                          input bit exp_err, input bit extra_start);
        int d0, cyc;
        d0 = done_cnt;
        pulse_start(a, l);
        cyc = 0;
        while (done_cnt == d0 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.start = (extra_start && cyc == 15);
        end
        bus.start = 1'b0;
        check("op_in_time", 32'(cyc < 5000), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("one_done", 32'(done_cnt - d0), 32'd1);
        check("error_flag", 32'(bus.error), 32'(exp_err));
        check("cs_high_after", 32'(cs_level), 32'd1);
        check("mosi_all_sent", 32'(exp_mosi.size()), 32'd0);
        check("data_all_out", 32'(exp_data.size()), 32'd0);
        check("busy_low_after", 32'(bus.busy), 32'd0);
        exp_mosi.delete();
        exp_data.delete();
    endtask

    initial begin
        logic [23:0] a;
        logic [15:0] l;
        int          cyc;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.addr  = 24'd0;
        bus.len   = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({bus.busy, bus.done, bus.error, bus.valid, bus.wb_stb, bus.wb_we,
                                    bus.wb_adr, bus.wb_wdata, bus.data}), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // basic read of four bytes
        push_op(24'h012345, 16'd4);
        run_op(24'h012345, 16'd4, 1'b0, 1'b0);
        check("mosi_count_case1", 32'(mosi_cnt), 32'd8);

        // zero-length read: command and address only
        push_op(24'hABCDEF, 16'd0);
        run_op(24'hABCDEF, 16'd0, 1'b0, 1'b0);
        check("mosi_count_len0", 32'(mosi_cnt), 32'd4);
        check("no_valid_len0", 32'(out_idx), 32'd0);

        // long backpressure on the second byte
        stall_req  = 1'b1;
        stall_done = 1'b0;
        a = 24'($urandom);
        push_op(a, 16'd4);
        run_op(a, 16'd4, 1'b0, 1'b0);
        check("stall_happened", 32'(stall_done), 32'd1);
        stall_req = 1'b0;

        // stuck busy status: poll timeout abort after the opcode
        stuck_busy = 1'b1;
        exp_mosi.push_back(8'h03);
        run_op(24'h000100, 16'd3, 1'b1, 1'b0);
        check("timeout_status_reads", 32'(status_reads), 32'd8);
        check("timeout_mosi_count", 32'(mosi_cnt), 32'd1);
        stuck_busy = 1'b0;

        // reset in the middle of the address phase, then a clean read
        push_op(24'h012345, 16'd4);
        pulse_start(24'h012345, 16'd4);
        cyc = 0;
        while (mosi_cnt < 2 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reached_addr_phase", 32'(cyc < 2000), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midop_reset_outputs", 32'({bus.busy, bus.done, bus.error, bus.valid, bus.wb_stb, bus.wb_we,
                                          bus.wb_adr, bus.wb_wdata, bus.data}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_mosi.delete();
        exp_data.delete();
        repeat (2) @(posedge clk);
        push_op(24'h012345, 16'd4);
        run_op(24'h012345, 16'd4, 1'b0, 1'b0);

        // start pulsed while busy must be ignored
        a = 24'($urandom);
        push_op(a, 16'd3);
        run_op(a, 16'd3, 1'b0, 1'b1);

        // random reads
        for (int k = 0; k < 5; k++) begin
            a = 24'($urandom);
            l = 16'($urandom_range(0, 6));
            push_op(a, l);
            run_op(a, l, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
